// File: rtl/wb_bus_arbiter_if.sv
// wb_bus_arbiter_if: one Wishbone link; master drives the request side,
// slave returns ack/err/read data.
interface wb_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [DW/8-1:0] sel;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_w;
    logic [DW-1:0] dat_r;
    logic          ack;
    logic          err;

    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  ack, err, dat_r
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output ack, err, dat_r
    );
endinterface

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: two-master round-robin Wishbone arbiter, grant held per cycle.
// Optional ack watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    wb_bus_arbiter_if.slave  m0,
    wb_bus_arbiter_if.slave  m1,
    wb_bus_arbiter_if.master s,
    output logic [1:0]       grant_o,
    output logic             timeout_o
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   req0, req1, own0, own1, stb_raw, fire;
    logic   unused_err;

    if (TIMEOUT < 2 || TIMEOUT > 65535 || DW % 8 != 0 || AW < 1) begin : g_bad_cfg
        $error("wb_bus_arbiter: illegal parameter set");
    end

    assign req0       = m0.cyc & m0.stb;
    assign req1       = m1.cyc & m1.stb;
    assign own0       = state_q == GNT0;
    assign own1       = state_q == GNT1;
    assign stb_raw    = own0 ? m0.stb : own1 & m1.stb;
    assign unused_err = s.err;

    // last_q = 1 out of reset so master 0 wins the first tie
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            GNT0: if (!m0.cyc) begin
                last_d  = 1'b0;
                state_d = req1 ? GNT1 : IDLE;
            end
            GNT1: if (!m1.cyc) begin
                last_d  = 1'b1;
                state_d = req0 ? GNT0 : IDLE;
            end
            default: state_d = (req0 & req1) ? (last_q ? GNT0 : GNT1) :
                               req0 ? GNT0 : req1 ? GNT1 : IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Outputs decode straight from the state so reset clears them at once
    always_comb begin
        s.cyc     = own0 ? m0.cyc : own1 & m1.cyc;
        s.stb     = stb_raw & ~fire;
        s.we      = own0 ? m0.we : own1 & m1.we;
        s.sel     = own0 ? m0.sel : own1 ? m1.sel : '0;
        s.adr     = own0 ? m0.adr : own1 ? m1.adr : '0;
        s.dat_w   = own0 ? m0.dat_w : own1 ? m1.dat_w : '0;
        m0.ack    = own0 & s.ack;
        m1.ack    = own1 & s.ack;
        m0.dat_r  = own0 ? s.dat_r : '0;
        m1.dat_r  = own1 ? s.dat_r : '0;
        m0.err    = own0 & fire;
        m1.err    = own1 & fire;
        grant_o   = {own1, own0};
        timeout_o = fire;
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign fire = stb_raw & ~s.ack & (cnt_q == CW'(TIMEOUT - 1));

    // Counts unacknowledged strobe cycles; holds while the owner idles stb
    always_comb begin
        cnt_d = (state_d != state_q || s.ack || fire) ? '0 :
                stb_raw ? cnt_q + CW'(1) : cnt_q;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
`else
    assign fire = 1'b0;
`endif
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter: directed scenarios plus randomized two-master traffic,
// checked by a scoreboard monitor against a round-robin reference model.
module tb_wb_bus_arbiter;
`ifdef WB_ARB_TIMEOUT_EN
    localparam int TO = 8;
    localparam bit WD = 1'b1;
`else
    localparam int TO = 255;
    localparam bit WD = 1'b0;
`endif

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  grant;
    logic        tmo;
    int          n_cmp = 0;
    int          n_bad = 0;
    xfer_t       q0[$];
    xfer_t       q1[$];
    int          ack_log[$];
    bit          mon_en = 1'b0;
    bit          slave_man = 1'b1;
    bit          man_ack = 1'b0;
    logic [31:0] man_dat = '0;
    int          slave_dmax = 0;
    int          own = -1;
    int          last = 1;

    wb_bus_arbiter_if #(.AW(32), .DW(32)) m0();
    wb_bus_arbiter_if #(.AW(32), .DW(32)) m1();
    wb_bus_arbiter_if #(.AW(32), .DW(32)) s();

    wb_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .m0       (m0),
        .m1       (m1),
        .s        (s),
        .grant_o  (grant),
        .timeout_o(tmo)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic xfer_t mk(input logic [31:0] a, input logic w, input logic [31:0] d,
                                 input logic [3:0] sl);
        xfer_t x;
        x.adr = a;
        x.we  = w;
        x.dat = d;
        x.sel = sl;
        return x;
    endfunction

    function automatic logic ack_of(input int id);
        return id == 0 ? m0.ack : m1.ack;
    endfunction

    function automatic logic [31:0] dat_of(input int id);
        return id == 0 ? m0.dat_r : m1.dat_r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string msg);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", msg);
    endtask

    task automatic drive(input int id, input logic c, input logic st, input xfer_t x);
        if (id == 0) begin
            m0.cyc = c; m0.stb = st; m0.we = x.we; m0.sel = x.sel; m0.adr = x.adr; m0.dat_w = x.dat;
        end else begin
            m1.cyc = c; m1.stb = st; m1.we = x.we; m1.sel = x.sel; m1.adr = x.adr; m1.dat_w = x.dat;
        end
    endtask

    // Bursts of 1..bmax transfers inside one cyc, then 1..imax+1 idle cycles
    task automatic master_run(input int id, input int n, input int bmax, input int imax);
        int done = 0;
        while (done < n) begin
            int bl = $urandom_range(1, bmax);
            for (int b = 0; b < bl && done < n; b++) begin
                xfer_t x = mk($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(1, 15)));
                int c;
                if (b > 0 && $urandom_range(0, 3) == 0) begin
                    drive(id, 1'b1, 1'b0, x);
                    @(posedge clk); #1;
                end
                drive(id, 1'b1, 1'b1, x);
                if (id == 0) q0.push_back(x); else q1.push_back(x);
                for (c = 0; c < 300; c++) begin
                    @(negedge clk);
                    if (ack_of(id)) break;
                end
                if (c == 300) fail($sformatf("m%0d_ack_wait: got no ack, expected one within 300 cycles", id));
                done++;
                @(posedge clk); #1;
            end
            drive(id, 1'b0, 1'b0, mk(0, 0, 0, 0));
            repeat ($urandom_range(0, imax)) @(posedge clk);
            @(posedge clk); #1;
        end
    endtask

    // Decoder model: manual mode, or ack after a random 0..slave_dmax wait
    initial begin
        int wl = 0;
        s.ack = 1'b0; s.err = 1'b0; s.dat_r = '0;
        forever begin
            @(posedge clk); #2;
            if (slave_man) begin
                s.ack = man_ack; s.dat_r = man_dat;
            end else if (s.cyc && s.stb) begin
                if (wl == 0) begin
                    s.ack = 1'b1; s.dat_r = rd_fn(s.adr); wl = $urandom_range(0, slave_dmax);
                end else begin
                    s.ack = 1'b0; wl--;
                end
            end else
                s.ack = 1'b0;
        end
    end

    // Monitor: reference owner model, scoreboard pops on every master ack
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            logic [1:0] eg;
            bit r0, r1;
            eg = own < 0 ? 2'b00 : own == 0 ? 2'b01 : 2'b10;
            chk("grant", 64'(grant), 64'(eg));
            chk("s_stb", 64'(s.stb), 64'(own == 0 ? m0.stb : own == 1 ? m1.stb : 1'b0));
            chk("s_cyc", 64'(s.cyc), 64'(own == 0 ? m0.cyc : own == 1 ? m1.cyc : 1'b0));
            chk("no_timeout", 64'({tmo, m0.err, m1.err}), 64'(0));
            for (int i = 0; i < 2; i++) begin
                if (ack_of(i)) begin
                    xfer_t x;
                    if (own != i) fail($sformatf("ack_owner: got ack on m%0d, expected owner %0d", i, own));
                    if ((i == 0 ? q0.size() : q1.size()) == 0)
                        fail($sformatf("m%0d_stray_ack: got ack, expected no pending transfer", i));
                    else begin
                        if (i == 0) x = q0.pop_front(); else x = q1.pop_front();
                        chk("rd_dat", 64'(dat_of(i)), 64'(rd_fn(x.adr)));
                        chk("s_adr", 64'(s.adr), 64'(x.adr));
                        chk("s_we", 64'(s.we), 64'(x.we));
                        chk("s_dat_w", 64'(s.dat_w), 64'(x.dat));
                        chk("s_sel", 64'(s.sel), 64'(x.sel));
                        ack_log.push_back(i);
                    end
                end else if (own != i)
                    chk("nonowner_dat", 64'(dat_of(i)), 64'(0));
            end
            r0 = m0.cyc & m0.stb;
            r1 = m1.cyc & m1.stb;
            if (own < 0)
                own = (r0 && r1) ? 1 - last : r0 ? 0 : r1 ? 1 : -1;
            else if (!(own == 0 ? m0.cyc : m1.cyc)) begin
                last = own;
                own  = (last == 0 ? r1 : r0) ? 1 - last : -1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish within 2ms");
        $fatal(1);
    end

    initial begin
        xfer_t z = mk(0, 0, 0, 0);
        int c0;
        drive(0, 1'b0, 1'b0, z);
        drive(1, 1'b0, 1'b0, z);
        repeat (2) @(posedge clk); #1;

        // Reset mid-transfer cuts grant, strobe and ack immediately
        rst_n = 1'b1;
        drive(0, 1'b1, 1'b1, mk(32'h3004_0000, 1'b0, 0, 4'hF));
        @(negedge clk); chk("t1_latency_grant", 64'(grant), 64'(0));
        @(negedge clk); chk("t1_grant", 64'(grant), 64'(1));
        man_ack = 1'b1; man_dat = 32'h1234_5678;
        @(posedge clk); #3;
        chk("t1_ack", 64'(m0.ack), 64'(1));
        chk("t1_dat", 64'(m0.dat_r), 64'(32'h1234_5678));
        rst_n = 1'b0; #1;
        chk("t1_rst_grant", 64'(grant), 64'(0));
        chk("t1_rst_stb", 64'({s.cyc, s.stb}), 64'(0));
        chk("t1_rst_ack", 64'(m0.ack), 64'(0));
        chk("t1_rst_dat", 64'(m0.dat_r), 64'(0));
        man_ack = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk); chk("t1_post_rst_grant", 64'(grant), 64'(0));
        @(negedge clk); chk("t1_regrant", 64'(grant), 64'(1));
        @(posedge clk); #1; drive(0, 1'b0, 1'b0, z);
        @(negedge clk); chk("t1_release_cycle", 64'(grant), 64'(1));
        @(negedge clk); chk("t1_idle", 64'(grant), 64'(0));

        // Tie after reset goes to m0, hand-over to m1 with no idle cycle
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        drive(0, 1'b1, 1'b1, mk(32'h3000_0010, 1'b0, 0, 4'hF));
        drive(1, 1'b1, 1'b1, mk(32'h3001_0020, 1'b0, 0, 4'hF));
        man_ack = 1'b1; man_dat = 32'h0BAD_F00D;
        @(negedge clk);
        chk("t2_idle_grant", 64'(grant), 64'(0));
        chk("stray_ack", 64'({m0.ack, m1.ack}), 64'(0));
        chk("stray_dat", 64'(m0.dat_r), 64'(0));
        @(negedge clk);
        chk("t2_grant", 64'(grant), 64'(1));
        chk("t2_m0_ack", 64'(m0.ack), 64'(1));
        chk("t2_m0_dat", 64'(m0.dat_r), 64'(32'h0BAD_F00D));
        chk("t2_m1_ack", 64'(m1.ack), 64'(0));
        chk("t2_m1_dat", 64'(m1.dat_r), 64'(0));
        man_ack = 1'b0;
        @(posedge clk); #1; drive(0, 1'b0, 1'b0, z);
        @(negedge clk); chk("t2_release_cycle", 64'(grant), 64'(1));
        @(negedge clk); chk("t2_handover", 64'(grant), 64'(2));
        @(posedge clk); #1; drive(1, 1'b0, 1'b0, z);
        @(negedge clk);
        @(negedge clk); chk("t2_idle", 64'(grant), 64'(0));

        // m1 read routed back, m0 sees nothing
        @(posedge clk); #1; drive(1, 1'b1, 1'b1, mk(32'h3005_0000, 1'b0, 0, 4'hF));
        @(negedge clk); chk("t4_stb_latency", 64'(s.stb), 64'(0));
        @(negedge clk);
        chk("t4_grant", 64'(grant), 64'(2));
        chk("t4_s_adr", 64'(s.adr), 64'(32'h3005_0000));
        man_ack = 1'b1; man_dat = 32'hCAFE_0001;
        @(negedge clk);
        chk("t4_m1_ack", 64'(m1.ack), 64'(1));
        chk("t4_m1_dat", 64'(m1.dat_r), 64'(32'hCAFE_0001));
        chk("t4_m0_quiet", 64'({m0.ack, m0.dat_r}), 64'(0));
        man_ack = 1'b0; man_dat = '0;
        @(posedge clk); #1; drive(1, 1'b0, 1'b0, z);
        @(negedge clk);
        @(negedge clk); chk("t4_idle", 64'(grant), 64'(0));

        // Unacknowledged strobe: watchdog pulse every TO strobe cycles, or none
        @(posedge clk); #1; drive(0, 1'b1, 1'b1, mk(32'h3FFF_0000, 1'b0, 0, 4'hF));
        @(negedge clk); chk("wd_stb_latency", 64'(s.stb), 64'(0));
        for (int j = 0; j < 20; j++) begin
            bit ex;
            @(negedge clk);
            ex = WD && (j % TO == TO - 1);
            chk("wd_timeout", 64'(tmo), 64'(ex));
            chk("wd_err", 64'(m0.err), 64'(ex));
            chk("wd_stb", 64'(s.stb), 64'(!ex));
            chk("wd_grant", 64'(grant), 64'(1));
            chk("wd_ack", 64'(m0.ack), 64'(0));
        end
        @(posedge clk); #1; drive(0, 1'b0, 1'b0, z);
        @(negedge clk);
        @(negedge clk); chk("wd_release", 64'(grant), 64'(0));

        // Single transfers from both masters alternate strictly
        @(posedge clk); #1; rst_n = 1'b0;
        own = -1; last = 1;
        q0.delete(); q1.delete(); ack_log.delete();
        @(posedge clk); #1; rst_n = 1'b1;
        slave_man = 1'b0; slave_dmax = 0; mon_en = 1'b1;
        fork
            master_run(0, 4, 1, 0);
            master_run(1, 4, 1, 0);
        join
        repeat (3) @(posedge clk); #1;
        chk("t3_ack_total", 64'(ack_log.size()), 64'(8));
        c0 = 0;
        foreach (ack_log[i]) begin
            chk($sformatf("t3_order_%0d", i), 64'(ack_log[i]), 64'(i % 2));
            if (ack_log[i] == 0) c0++;
        end
        chk("t3_m0_acks", 64'(c0), 64'(4));

        // Randomized bursts, gaps and slave wait states
        slave_dmax = 3;
        fork
            master_run(0, 15, 3, 3);
            master_run(1, 15, 3, 3);
        join
        repeat (3) @(posedge clk); #1;
        mon_en = 1'b0;
        chk("q0_drained", 64'(q0.size()), 64'(0));
        chk("q1_drained", 64'(q1.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
